// File: rtl/battleship_pkg.sv
// Shared board geometry, placement FSM states and the ship footprint helper.
package battleship_pkg;

  localparam int BOARD_W = 5;
  localparam int CELLS   = 25;

  typedef enum logic [1:0] {IDLE, PLACE, CHECK, DONE} state_t;

  // Cells h, h-1, ... h-size+1; anything that would spill into the previous row is dropped.
  function automatic logic [CELLS-1:0] ship_mask(input logic [4:0] head, input logic [2:0] size);
    logic [CELLS-1:0] m;
    logic [2:0]       col;
    m   = '0;
    col = 3'(head % 5'd5);
    for (int i = 0; i < BOARD_W; i++) begin
      if ((i < int'(size)) && (i <= int'(col)))
        m[head - 5'(i)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ship_mask_gen.sv
// Candidate footprint and legality (in-row bounds, no overlap with committed ships).
module ship_mask_gen
  import battleship_pkg::*;
(
  input  logic [4:0]       head,
  input  logic [2:0]       size,
  input  logic [CELLS-1:0] occupancy,
  output logic [CELLS-1:0] mask,
  output logic             legal
);

  logic [2:0] col;

  assign col   = 3'(head % 5'd5);
  assign mask  = ship_mask(head, size);
  assign legal = (({1'b0, col} + 4'd1) >= {1'b0, size}) && ((mask & occupancy) == '0);

endmodule

// File: rtl/ship_placement.sv
// Ship placement controller for a 5x5 board; feeds heads/sizes to the hit register.
// Optional SHIP_PLACEMENT_AUTO_EN adds an `auto` input that places ships from an LFSR.
module ship_placement
  import battleship_pkg::*;
#(
  parameter int NUM_SHIPS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mv_up,
  input  logic             mv_down,
  input  logic             mv_left,
  input  logic             mv_right,
  input  logic             confirm,
`ifdef SHIP_PLACEMENT_AUTO_EN
  input  logic             auto,
`endif
  output logic [4:0]       cursor,
  output logic [2:0]       ship_idx,
  output logic [CELLS-1:0] preview,
  output logic [CELLS-1:0] occupancy,
  output logic [4:0]       ship_head [0:4],
  output logic [2:0]       ship_size [0:4],
  output logic             reject,
  output logic             busy,
  output logic             done,
  output logic             setter
);

  state_t           state, nxt_state;
  logic [2:0]       row, col, nxt_row, nxt_col;
  logic [2:0]       nxt_idx;
  logic [CELLS-1:0] nxt_occ;
  logic [4:0]       nxt_heads [0:4];
  logic [4:0]       cand, nxt_cand;
  logic             nxt_reject, nxt_setter;

  logic [4:0]       gen_head;
  logic [2:0]       gen_size;
  logic [CELLS-1:0] gen_mask;
  logic             gen_legal;

  logic             do_confirm;
  logic [2:0]       cf_row, cf_col;
  logic [4:0]       cf_cell;

`ifdef SHIP_PLACEMENT_AUTO_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Auto mode relocates the cursor and self-confirms every PLACE cycle; rejects simply retry.
  assign do_confirm = confirm | auto;
  assign cf_row     = auto ? (lfsr[2:0] % 3'd5) : row;
  assign cf_col     = auto ? (lfsr[5:3] % 3'd5) : col;
`else
  assign do_confirm = confirm;
  assign cf_row     = row;
  assign cf_col     = col;
`endif

  assign cursor  = ({2'b0, row} * 5'd5) + {2'b0, col};
  assign cf_cell = ({2'b0, cf_row} * 5'd5) + {2'b0, cf_col};

  // One checker serves both the live preview and the CHECK decision on the latched candidate.
  assign gen_head = (state == CHECK) ? cand : cursor;
  assign gen_size = ship_idx + 3'd1;

  ship_mask_gen u_mask (
    .head      (gen_head),
    .size      (gen_size),
    .occupancy (occupancy),
    .mask      (gen_mask),
    .legal     (gen_legal)
  );

  assign preview = (state == PLACE) ? gen_mask : '0;
  assign busy    = (state == PLACE) || (state == CHECK);
  assign done    = (state == DONE);

  for (genvar k = 0; k < 5; k++) begin : g_size
    assign ship_size[k] = (k < NUM_SHIPS) ? 3'(k + 1) : 3'd0;
  end

  always_comb begin
    nxt_state  = state;
    nxt_row    = row;
    nxt_col    = col;
    nxt_idx    = ship_idx;
    nxt_occ    = occupancy;
    nxt_heads  = ship_head;
    nxt_cand   = cand;
    nxt_reject = 1'b0;
    nxt_setter = 1'b0;
    if (start) begin
      nxt_state = PLACE;
      nxt_row   = 3'd0;
      nxt_col   = 3'd4;
      nxt_idx   = 3'd0;
      nxt_occ   = '0;
      for (int k = 0; k < 5; k++) nxt_heads[k] = '0;
    end else begin
      case (state)
        PLACE: begin
          if (do_confirm) begin
            nxt_row   = cf_row;
            nxt_col   = cf_col;
            nxt_cand  = cf_cell;
            nxt_state = CHECK;
          end else if (mv_up) begin
            nxt_row = (row == 3'd0) ? 3'd4 : row - 3'd1;
          end else if (mv_down) begin
            nxt_row = (row == 3'd4) ? 3'd0 : row + 3'd1;
          end else if (mv_left) begin
            nxt_col = (col == 3'd0) ? 3'd4 : col - 3'd1;
          end else if (mv_right) begin
            nxt_col = (col == 3'd4) ? 3'd0 : col + 3'd1;
          end
        end
        CHECK: begin
          if (gen_legal) begin
            nxt_heads[ship_idx] = cand;
            nxt_occ             = occupancy | gen_mask;
            nxt_idx             = ship_idx + 3'd1;
            if (ship_idx == 3'(NUM_SHIPS - 1)) begin
              nxt_state  = DONE;
              nxt_setter = 1'b1;
            end else begin
              nxt_state = PLACE;
            end
          end else begin
            nxt_reject = 1'b1;
            nxt_state  = PLACE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      row       <= 3'd0;
      col       <= 3'd0;
      ship_idx  <= 3'd0;
      occupancy <= '0;
      for (int k = 0; k < 5; k++) ship_head[k] <= '0;
      reject    <= 1'b0;
      setter    <= 1'b0;
    end else begin
      state     <= nxt_state;
      row       <= nxt_row;
      col       <= nxt_col;
      ship_idx  <= nxt_idx;
      occupancy <= nxt_occ;
      ship_head <= nxt_heads;
      reject    <= nxt_reject;
      setter    <= nxt_setter;
    end
  end

  always_ff @(posedge clk) begin
    cand <= nxt_cand;
  end

endmodule
